alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
//  Registered execute stage that sits directly downstream of the 8-bit add/sub and bitwise logic circuits.
//  Accepts one op per valid/ready handshake and produces a registered result plus a persistent flag
//  register {C,V,N,Z}. Adds a multi-cycle shift-and-add MUL built on the same ripple adder.
// PARAMETERS
//  W    8   datapath width (>=2); MUL iterates W cycles
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  in_valid   in   1   op/a/b/c valid
//  in_ready   out  1   stage can accept; transfer when in_valid&&in_ready
//  op         in   3   000 ADD,001 SUB,010 ADC,011 XOR,100 OR,101 AND,110 MUL,111 NOP
//  a          in   W   operand A
//  b          in   W   operand B
//  out_valid  out  1   result/flags valid
//  out_ready  in   1   consumer takes result when out_valid&&out_ready
//  result     out  W   registered result
//  flags      out  4   {C,V,N,Z} flag register
//  busy       out  1   MUL in progress
// BEHAVIOUR
//  Reset: out_valid=0, result=0, flags=0, busy=0, state=IDLE, counter=0; in_ready=1 once rst_n high.
//  Reset mid-MUL aborts the op; no result emitted.
//  FSM: IDLE -> MULT on accepted MUL; MULT -> IDLE after W iterations. Others stay in IDLE.
//  in_ready = (state==IDLE) && (!out_valid || out_ready); combinational, no in_valid dependency.
//  Single-cycle ops: accepted at edge k -> result, flags and out_valid=1 written at edge k.
//  MUL: acceptance edge latches a,b and clears the W-bit accumulator; W iteration edges follow
//   (add a<<i when b[i]); the final edge writes result=low W bits and sets out_valid.
//  out_valid clears on out_ready unless a new op completes the same edge (back-to-back 1/cycle).
//  While out_valid && !out_ready: result and flags held stable, in_ready=0.
//  ADD: a+b+0. SUB: a+~b+1 (C=1 means no borrow). ADC: a+b+flags.C sampled at acceptance.
//  Arithmetic flags: C=carry out of MSB; V=carry into MSB ^ carry out; N=result[W-1]; Z=(result==0).
//  XOR/OR/AND: C=0, V=0, N and Z from result.
//  MUL: C=|(high W bits of full 2W product); V=0; N and Z from result (low W bits).
//  NOP: result=a, flags unchanged, out_valid still asserted (occupies a slot).
//  Flags change only on the edge that writes a result; they persist across idle cycles.
//  Results wrap modulo 2^W (MUL drops high half).
// CONFIGURATION
//  ALU_EXEC_SAT_EN defined: ADD/SUB/ADC saturate on signed overflow (V=1): result = 0x7F..F if the
//   operation's effective A operand was non-negative, else 0x80..0. Flags C and V are computed from the
//   unsaturated sum; N and Z are computed from the saturated result.
//  Not defined: all arithmetic wraps; no saturation logic synthesised.
// TESTING
//  1 ADD a=0x7F b=0x01 -> result 0x80, flags C0 V1 N1 Z0, out_valid 1 cycle after accept
//    (with ALU_EXEC_SAT_EN: result 0x7F, V1 N0).
//  2 SUB a=0x05 b=0x05 -> 0x00, C1 V0 N0 Z1; SUB 0x03-0x05 -> 0xFE, C0 N1.
//  3 MUL a=0x13 b=0x11 -> result 0x43, C1; out_valid exactly 8 cycles after accept;
//    busy=1 and in_ready=0 throughout.
//  4 XOR 0xF0^0xFF with out_ready=0 for 3 cycles -> 0x0F held stable, in_ready=0; a new op
//    is accepted on the cycle out_ready rises.
//  5 ADD 0xFF+0x01 (0x00, C1 Z1) then ADC 0x00+0x00 -> 0x01, C0 Z0; then NOP -> flags unchanged.
//  6 rst_n low at MUL iteration 4 -> out_valid 0, flags 0, busy 0; after release in_ready=1,
//    and a following AND 0xAA&0x0F returns 0x0A.

Source files
------------

// File: rtl/alu_exec_stage.sv
// ============================================================================
// alu_exec_stage: registered ALU execute stage with {C,V,N,Z} flags and a
// W-cycle shift-and-add MUL. Optional macro ALU_EXEC_SAT_EN: saturating ADD/SUB/ADC.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_exec_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags,
  output logic         busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  localparam int              CW   = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0]   LAST = CW'(W - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MULT = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] count;
  logic [W-1:0]  mul_a;
  logic [W-1:0]  acc_hi;
  logic [W-1:0]  mul_lo;

  logic          accept;
  logic          mul_done;
  logic [W-1:0]  b_eff;
  logic          cin;
  logic [W-1:0]  add_x;
  logic [W-1:0]  add_y;
  logic [W:0]    carry;
  logic [W-1:0]  sum;
  logic          arith_v;
  logic [W-1:0]  alu_res;
  logic          alu_c;
  logic          alu_v;
  logic [3:0]    alu_flags;
  logic [W-1:0]  mul_hi_nxt;
  logic [W-1:0]  mul_lo_nxt;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == MULT);
  assign mul_done = (state == MULT) && (count == LAST);

  always_comb begin
    b_eff = b;
    cin   = 1'b0;
    case (op)
      OP_SUB: begin
        b_eff = ~b;
        cin   = 1'b1;
      end
      OP_ADC:  cin = flags[3];
      default: ;
    endcase
  end

  // One ripple adder serves both the single-cycle arithmetic and each MUL step.
  assign add_x    = busy ? acc_hi : a;
  assign add_y    = busy ? (mul_lo[0] ? mul_a : '0) : b_eff;
  assign carry[0] = busy ? 1'b0 : cin;

  for (genvar i = 0; i < W; i++) begin : g_ripple
    assign sum[i]     = add_x[i] ^ add_y[i] ^ carry[i];
    assign carry[i+1] = (add_x[i] & add_y[i]) | (carry[i] & (add_x[i] ^ add_y[i]));
  end

  assign arith_v = carry[W] ^ carry[W-1];

  // Right-shifting multiply: {acc_hi, mul_lo} holds the partial 2W-bit product.
  assign mul_hi_nxt = {carry[W], sum[W-1:1]};
  assign mul_lo_nxt = {sum[0], mul_lo[W-1:1]};

  always_comb begin
    alu_res = sum;
    alu_c   = carry[W];
    alu_v   = arith_v;
    case (op)
      OP_XOR: begin
        alu_res = a ^ b;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
      end
      OP_OR: begin
        alu_res = a | b;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
      end
      OP_AND: begin
        alu_res = a & b;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
      end
      default: ;
    endcase
`ifdef ALU_EXEC_SAT_EN
    if (((op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC)) && arith_v) begin
      alu_res = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
    alu_flags = {alu_c, alu_v, alu_res[W-1], (alu_res == '0)};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && (op == OP_MUL)) state_nxt = MULT;
      MULT:    if (count == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      mul_a     <= '0;
      acc_hi    <= '0;
      mul_lo    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= 4'b0000;
    end else begin
      if (state == MULT) begin
        acc_hi <= mul_hi_nxt;
        mul_lo <= mul_lo_nxt;
        count  <= mul_done ? '0 : count + 1'b1;
      end
      if (accept && (op == OP_MUL)) begin
        mul_a  <= a;
        mul_lo <= b;
        acc_hi <= '0;
        count  <= '0;
      end

      if (accept && (op != OP_MUL)) begin
        out_valid <= 1'b1;
        if (op == OP_NOP) begin
          result <= a;
        end else begin
          result <= alu_res;
          flags  <= alu_flags;
        end
      end else if (mul_done) begin
        out_valid <= 1'b1;
        result    <= mul_lo_nxt;
        flags     <= {(|mul_hi_nxt), 1'b0, mul_lo_nxt[W-1], (mul_lo_nxt == '0)};
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
// ============================================================================
// tb_alu_exec_stage: table-driven vectors with a result/flag scoreboard, plus
// sequences for MUL latency, output back-pressure and reset mid-MUL.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_exec_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [3:0] flags;
  logic       busy;

  alu_exec_stage #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] fl;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic [3:0] fl;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[16];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {24'h0, result}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", {24'h0, result}, {24'h0, e.res});
        chk("flags", {28'h0, flags}, {28'h0, e.fl});
      end
    end
  end

  task automatic send(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                      input logic [7:0] er, input logic [3:0] ef, output int waited);
    bit ok;
    ok       = 1'b0;
    waited   = 0;
    in_valid = 1'b1;
    op       = o;
    a        = aa;
    b        = bb;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      waited = k + 1;
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back('{res: er, fl: ef});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 50; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  w;
    int  lat;
    bit  bad;

    vecs[0]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 4'b0110};
`ifdef ALU_EXEC_SAT_EN
    vecs[0]  = '{3'b000, 8'h7F, 8'h01, 8'h7F, 4'b0100};
`endif
    vecs[1]  = '{3'b001, 8'h05, 8'h05, 8'h00, 4'b1001};
    vecs[2]  = '{3'b001, 8'h03, 8'h05, 8'hFE, 4'b0010};
    vecs[3]  = '{3'b011, 8'hF0, 8'hFF, 8'h0F, 4'b0000};
    vecs[4]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 4'b1001};
    vecs[5]  = '{3'b010, 8'h00, 8'h00, 8'h01, 4'b0000};
    vecs[6]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 4'b1001};
    vecs[7]  = '{3'b111, 8'h5A, 8'h33, 8'h5A, 4'b1001};
    vecs[8]  = '{3'b100, 8'h80, 8'h01, 8'h81, 4'b0010};
    vecs[9]  = '{3'b101, 8'hAA, 8'h0F, 8'h0A, 4'b0000};
    vecs[10] = '{3'b000, 8'h40, 8'h40, 8'h80, 4'b0110};
    vecs[11] = '{3'b001, 8'h80, 8'h01, 8'h7F, 4'b1100};
`ifdef ALU_EXEC_SAT_EN
    vecs[10] = '{3'b000, 8'h40, 8'h40, 8'h7F, 4'b0100};
    vecs[11] = '{3'b001, 8'h80, 8'h01, 8'h80, 4'b1110};
`endif
    vecs[12] = '{3'b110, 8'h13, 8'h11, 8'h43, 4'b1000};
    vecs[13] = '{3'b110, 8'hFF, 8'hFF, 8'h01, 4'b1000};
    vecs[14] = '{3'b110, 8'h10, 8'h10, 8'h00, 4'b1001};
    vecs[15] = '{3'b110, 8'h07, 8'h03, 8'h15, 4'b0000};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 3'b111;
    a         = 8'h00;
    b         = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_result", {24'h0, result}, 32'd0);
    chk("rst_flags", {28'h0, flags}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].fl, w);
    end
    drain();

    // MUL latency and busy/in_ready during iteration
    send(3'b110, 8'h13, 8'h11, 8'h43, 4'b1000, w);
    lat = 0;
    bad = 1'b0;
    while (!out_valid && lat < 20) begin
      if (!busy || in_ready) bad = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("mul_latency", lat, 32'd8);
    chk("mul_busy_window", {31'h0, bad}, 32'd0);
    chk("mul_busy_cleared", {31'h0, busy}, 32'd0);
    drain();

    // Back-pressure: result held, next op accepted as soon as out_ready rises
    out_ready = 1'b0;
    send(3'b011, 8'hF0, 8'hFF, 8'h0F, 4'b0000, w);
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (result !== 8'h0F || flags !== 4'b0000 || !out_valid || in_ready) bad = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("hold_stable", {31'h0, bad}, 32'd0);
    out_ready = 1'b1;
    send(3'b000, 8'h01, 8'h01, 8'h02, 4'b0000, w);
    chk("accept_on_ready", w, 32'd1);
    drain();

    // Reset during MUL iteration 4 aborts the op
    send(3'b110, 8'h13, 8'h11, 8'h43, 4'b1000, w);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("abort_out_valid", {31'h0, out_valid}, 32'd0);
    chk("abort_flags", {28'h0, flags}, 32'd0);
    chk("abort_busy", {31'h0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_in_ready", {31'h0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    send(3'b101, 8'hAA, 8'h0F, 8'h0A, 4'b0000, w);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
